// File: rtl/bcd_counter_mux_display.sv
// bcd_counter_mux_display
// N-digit BCD up/down counter driving a time-multiplexed, common-anode
// 7-segment display (active-low anodes and segments).
// Optional build macro: LEADING_ZERO_BLANK_EN -- blanks zero digits that have
// no non-zero digit above them (digit 0 is never blanked).
// Single clk domain; slow timing comes from the tick and scan strobes.

module bcd_counter_mux_display #(
    parameter int CLK_HZ     = 100000000,
    parameter int TICK_HZ    = 1,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    tick,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TDIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SDIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TDIV_W-1:0] TICK_LAST = TDIV_W'(TICK_DIV - 1);
    localparam logic [SDIV_W-1:0] SCAN_LAST = SDIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [TDIV_W-1:0]       tick_div_q, tick_div_d;
    logic [SDIV_W-1:0]       scan_div_q, scan_div_d;
    logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
    logic [4*NUM_DIGITS-1:0] count_q, count_d;
    logic                    wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;

    logic [4*NUM_DIGITS-1:0] step_val;
    logic                    step_wrap;
    logic [4*NUM_DIGITS-1:0] load_sat;
    logic                    scan_last;
    logic [3:0]              sel_digit;
    logic                    sel_blank;

    // Active-low {g..a} pattern for one BCD digit; non-decimal codes blank
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Free-running tick divider; tick is high while the divider sits at its last value
    always_comb begin
        tick_div_d = (tick_div_q == TICK_LAST) ? '0 : tick_div_q + TDIV_W'(1);
    end

    assign tick = (tick_div_q == TICK_LAST);

    // BCD +/-1 with ripple carry/borrow; carry out of the top digit is the wrap
    always_comb begin
        logic [3:0] dig;
        logic       cy;
        step_val = count_q;
        cy       = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (cy) begin
                if (up_dn) begin
                    if (dig >= 4'd9) begin
                        dig = 4'd0;
                    end else begin
                        dig = dig + 4'd1;
                        cy  = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        dig = 4'd9;
                    end else begin
                        dig = dig - 4'd1;
                        cy  = 1'b0;
                    end
                end
            end
            step_val[4*i +: 4] = dig;
        end
        step_wrap = cy;
    end

    // Saturate out-of-range load digits to 9 so the count always holds valid BCD
    always_comb begin
        load_sat = load_val;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    // Count update priority: clear, then load, then enabled tick step, else hold
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_sat;
        end else if (tick && en) begin
            count_d = step_val;
            wrap_d  = step_wrap;
        end
    end

    // Scan divider and digit index; index advances on divider terminal count
    always_comb begin
        scan_last  = (scan_div_q == SCAN_LAST);
        scan_div_d = scan_last ? '0 : scan_div_q + SDIV_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_last) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

    // Select the digit under the current index and decide whether it is blanked
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic zero_above;
`endif
        sel_digit = 4'd0;
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                sel_digit = count_q[4*i +: 4];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; a digit is leading-zero while everything
        // from it upward is zero. Digit 0 stays lit so a zero count reads "0".
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (count_q[4*i +: 4] == 4'd0);
            if ((scan_idx_q == IDX_W'(i)) && zero_above && (i != 0)) begin
                sel_blank = 1'b1;
            end
        end
`endif
    end

    // Anode and segment values registered together so they always match
    always_comb begin
        an_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
        seg_d = sel_blank ? 8'hFF : {1'b1, seg_decode(sel_digit)};
    end

    // All state registers; reset leaves the display dark and the count at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_div_q <= '0;
            scan_div_q <= '0;
            scan_idx_q <= '0;
            count_q    <= '0;
            wrap_q     <= 1'b0;
            an_q       <= '1;
            seg_q      <= 8'hFF;
        end else begin
            tick_div_q <= tick_div_d;
            scan_div_q <= scan_div_d;
            scan_idx_q <= scan_idx_d;
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_bcd_counter_mux_display.sv
module tb_bcd_counter_mux_display;

    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;
    localparam int ND       = 4;
    localparam int SCAN_DIV = 4;
    localparam int TDIV     = CLK_HZ / TICK_HZ;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          up_dn;
    logic          clr;
    logic          load;
    logic [15:0]   load_val;
    logic [15:0]   count_bcd;
    logic          tick;
    logic          wrap;
    logic [3:0]    an;
    logic [7:0]    seg;

    bcd_counter_mux_display #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count_bcd(count_bcd),
        .tick     (tick),
        .wrap     (wrap),
        .an       (an),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc;           // clock edges since reset release
    int         cnt;           // model count as a plain integer 0..9999
    logic       last_tick;     // model: tick was high at the edge just taken
    logic [3:0] last_an_e;     // model: anode pattern expected after that edge
    logic [6:0] seg_lut [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] lv);
        int r;
        int d;
        r = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int idx);
        int pw;
        int d;
        pw = 1;
        for (int i = 0; i < idx; i++) pw = pw * 10;
        d = (v / pw) % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx != 0 && v < pw) return 8'hFF;
`endif
        return {1'b1, seg_lut[d]};
    endfunction

    // One clock: predict from the spec rules, take the edge, compare all outputs
    task automatic step();
        int         idx;
        int         nxt;
        logic       t_e;
        logic       w_e;
        logic [7:0] s_e;
        logic [3:0] a_e;
        t_e = ((cyc % TDIV) == TDIV - 1);
        idx = (cyc / SCAN_DIV) % ND;
        s_e = exp_seg(cnt, idx);
        a_e = 4'b1111;
        a_e[idx] = 1'b0;
        nxt = cnt;
        w_e = 1'b0;
        if (clr) nxt = 0;
        else if (load) nxt = from_load(load_val);
        else if (t_e && en) begin
            if (up_dn) begin
                w_e = (cnt == 9999);
                nxt = (cnt + 1) % 10000;
            end else begin
                w_e = (cnt == 0);
                nxt = (cnt + 9999) % 10000;
            end
        end
        last_tick = t_e;
        last_an_e = a_e;
        @(posedge clk);
        #1;
        cnt = nxt;
        cyc++;
        chk("count", 32'(count_bcd), 32'(to_bcd(cnt)));
        chk("wrap", 32'(wrap), 32'(w_e));
        chk("an", 32'(an), 32'(a_e));
        chk("seg", 32'(seg), 32'(s_e));
        chk("tick", 32'(tick), 32'((cyc % TDIV) == TDIV - 1));
    endtask

    task automatic run_to_tick();
        for (int k = 0; k < TDIV + 2; k++) begin
            step();
            if (last_tick) return;
        end
        chk("tick_timeout", 32'(last_tick), 32'd1);
    endtask

    task automatic run_to_slot(input logic [3:0] a);
        for (int k = 0; k < 4 * SCAN_DIV * ND; k++) begin
            step();
            if (last_an_e == a) return;
        end
        chk("slot_timeout", 32'(an), 32'(a));
    endtask

    task automatic do_load(input logic [15:0] v);
        load_val = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        int         nt;
        logic [7:0] dexp [4];

        seg_lut[0] = 7'b1000000; seg_lut[1] = 7'b1111001;
        seg_lut[2] = 7'b0100100; seg_lut[3] = 7'b0110000;
        seg_lut[4] = 7'b0011001; seg_lut[5] = 7'b0010010;
        seg_lut[6] = 7'b0000010; seg_lut[7] = 7'b1111000;
        seg_lut[8] = 7'b0000000; seg_lut[9] = 7'b0010000;

        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = '0; cyc = 0; cnt = 0; last_tick = 1'b0; last_an_e = 4'hF;

        // Reset held for three clocks
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_count", 32'(count_bcd), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        rst_n = 1'b1;

        // Count up 12 ticks from zero, checking first tick and first scan slot
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 12 * TDIV; i++) begin
            step();
            if (i == 1) chk("t1_an_first", 32'(an), 32'(4'b1110));
            if (i == TDIV - 2) chk("t1_tick_low", 32'(tick), 32'd0);
            if (i == TDIV - 1) chk("t1_tick_first", 32'(tick), 32'd1);
        end
        chk("t2_count", 32'(count_bcd), 32'h0012);
        en = 1'b0;
        run_to_slot(4'b1101);
        chk("t2_an_d1", 32'(an), 32'(4'b1101));
        chk("t2_seg_d1", 32'(seg), 32'(8'b11111001));

        // Wrap up from 9999 and back down
        do_load(16'h9999);
        en = 1'b1; up_dn = 1'b1;
        run_to_tick();
        chk("t3_up_count", 32'(count_bcd), 32'h0000);
        chk("t3_up_wrap", 32'(wrap), 32'd1);
        step();
        chk("t3_up_wrap_end", 32'(wrap), 32'd0);
        up_dn = 1'b0;
        run_to_tick();
        chk("t3_dn_count", 32'(count_bcd), 32'h9999);
        chk("t3_dn_wrap", 32'(wrap), 32'd1);
        step();
        chk("t3_dn_wrap_end", 32'(wrap), 32'd0);
        en = 1'b0;

        // Load saturation, then clr beats load on a tick edge
        do_load(16'h12AF);
        chk("t4_load_sat", 32'(count_bcd), 32'h1299);
        clr = 1'b1; load = 1'b1; load_val = 16'h0000; en = 1'b1; up_dn = 1'b0;
        run_to_tick();
        chk("t4_clr_count", 32'(count_bcd), 32'h0000);
        chk("t4_clr_wrap", 32'(wrap), 32'd0);
        clr = 1'b0; load = 1'b0; en = 1'b0;

        // Disabled count across five ticks, tick cadence unchanged
        do_load(16'h0345);
        nt = 0;
        for (int i = 0; i < 5 * TDIV; i++) begin
            step();
            if (tick === 1'b1) nt++;
        end
        chk("t5_tick_count", 32'(nt), 32'd5);
        chk("t5_hold", 32'(count_bcd), 32'h0345);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_arst_an", 32'(an), 32'hF);
        chk("t5_arst_count", 32'(count_bcd), 32'h0);
        chk("t5_arst_seg", 32'(seg), 32'hFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0; cnt = 0;
        step();
        chk("t5_restart_an", 32'(an), 32'(4'b1110));

        // Leading-zero handling at 0070 and at 0
        do_load(16'h0070);
`ifdef LEADING_ZERO_BLANK_EN
        dexp[3] = 8'hFF; dexp[2] = 8'hFF;
`else
        dexp[3] = 8'hC0; dexp[2] = 8'hC0;
`endif
        dexp[1] = 8'hF8; dexp[0] = 8'hC0;
        for (int d = 0; d < ND; d++) begin
            logic [3:0] a;
            a = 4'hF;
            a[d] = 1'b0;
            run_to_slot(a);
            chk("t6_seg_0070", 32'(seg), 32'(dexp[d]));
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        dexp[3] = 8'hFF; dexp[2] = 8'hFF; dexp[1] = 8'hFF;
`else
        dexp[3] = 8'hC0; dexp[2] = 8'hC0; dexp[1] = 8'hC0;
`endif
        dexp[0] = 8'hC0;
        for (int d = 0; d < ND; d++) begin
            logic [3:0] a;
            a = 4'hF;
            a[d] = 1'b0;
            run_to_slot(a);
            chk("t6_seg_zero", 32'(seg), 32'(dexp[d]));
        end

        // Randomised controls against the model
        for (int i = 0; i < 800; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            up_dn = $urandom_range(0, 1) == 1;
            clr   = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 2))
                0:       load_val = 16'h9999;
                1:       load_val = 16'h0000;
                default: load_val = 16'($urandom);
            endcase
            step();
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
